pipe_stage_chain: RTL
=====================

Name: pipe_stage_chain

Overview:
- Parametrised elastic pipeline register chain for the core and its peripherals.
- Replaces the hand-coded inter-stage registers with a generic chain of DEPTH stages, each WIDTH bits wide.
- Each stage has a valid bit, a per-stage stall (hold) and a per-stage flush (kill).
- Valid/ready handshakes on the input and output sides give full-throughput back-pressure that the fixed registers lack.

Parameters:
WIDTH, 32, payload bits per stage (>=1)
DEPTH, 4, number of register stages (>=1); stage 0 is input side, stage DEPTH-1 drives the output
CNT_W, 32, width of perf counters (used only with PIPE_PERF_CNT_EN)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  upstream offers in_data
in_ready  out  1  chain accepts in_data this cycle
in_data  in  WIDTH  payload into stage 0
out_valid  out  1  stage DEPTH-1 presents out_data
out_ready  in  1  downstream accepts out_data
out_data  out  WIDTH  payload of stage DEPTH-1
stall  in  DEPTH  bit i: stage i holds contents, sends nothing, receives nothing
flush  in  DEPTH  bit i: kill stage i contents at next edge
occupancy  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- State: valid[DEPTH-1:0], data[DEPTH][WIDTH].
- Reset (rst=0, async): all valid=0 and all data=0 immediately.
  - Resulting outputs: out_valid=0, occupancy=0, out_data=0.
  - in_ready=1 unless stall[0] or flush[0].
- Per-stage handshake (combinational; next(DEPTH-1) = out_ready):
  - move[i] = valid[i] & ~stall[i] & ~flush[i] & acc[i+1]
  - acc[i] = ~stall[i] & ~flush[i] & (~valid[i] | move[i])
  - in_ready = acc[0]; out_valid = valid[DEPTH-1] & ~stall[DEPTH-1] & ~flush[DEPTH-1].
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Update on each rising edge:
  - flush[i]=1: valid[i]<=0; flush overrides stall; the killed entry never moves downstream.
  - Else if acc[i]: valid[i] <= (i==0 ? in_valid : move[i-1]). data[i] loads only when the new valid is 1; on a bubble, data holds (no toggle).
  - Else (stalled, or blocked with valid=1): valid and data hold.
- Latency: DEPTH cycles from in_fire to out_valid with no stall/back-pressure.
- Throughput: 1 item/cycle with out_ready=1 steady.
- Ready is pass-through. A full chain with out_ready rising accepts new input in the same cycle.
- Ordering: strict FIFO; entries never overtake; no duplication.
- Stall in mid-chain:
  - Stages below i back up.
  - Stages above i drain and receive bubbles.
- occupancy = popcount(valid), driven from registers only, with no combinational input path.
- Simultaneous flush[i] with an upstream move into i: acc[i]=0, so the upstream entry holds and is not lost.
- Reset asserted mid-transfer: all in-flight entries are discarded; no partial outputs.
- DEPTH=1 is legal and behaves as a single full-throughput register slice.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_bubble_cnt [CNT_W]: +1 per cycle with out_ready=1 & out_valid=0.
  - perf_flush_cnt [CNT_W]: + popcount(valid & flush) per cycle.
  - Both counters saturate at all-ones and reset to 0 on rst=0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: fill 3 entries, pulse rst=0 mid-cycle -> out_valid=0 and occupancy=0 without waiting for a clock edge; after release, in_ready=1.
- Streaming (DEPTH=4): in_valid=1 with data 0x1,0x2,0x3..., out_ready=1 -> out_data=0x1 is valid on the 4th edge after the first in_fire, then one item per cycle with no gaps.
- Back-pressure: out_ready=0, offer 6 items -> 4 accepted, in_ready=0, occupancy=4. Raise out_ready -> in_ready=1 in the same cycle; outputs 0x1..0x6 arrive in order.
- Stall: full chain A(s3) B(s2) C(s1) D(s0), stall[1]=1 for 3 cycles, out_ready=1 -> A and B exit, stages 2 and 3 go invalid, C and D hold, in_ready=0. Release -> C then D then new input.
- Flush: entries in s0 and s1, flush=4'b0011 together with stall[1]=1 -> both killed (flush wins), occupancy drops by 2, neither entry ever appears on out_data. Upstream in_data offered that cycle is not accepted (in_ready=0).
- Perf (with PIPE_PERF_CNT_EN): 5 idle cycles with out_ready=1 -> perf_bubble_cnt=5. Flush of 3 valid stages -> perf_flush_cnt=3. Preload near all-ones with CNT_W=4 -> counters hold at 4'hF.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Elastic pipeline register chain: DEPTH stages of WIDTH-bit payload, each
//   with a valid bit, a per-stage stall (hold) and a per-stage flush (kill).
//   Valid/ready on both ends; ready propagates combinationally from the
//   output back to the input, so a full chain keeps 1 item/cycle throughput.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   upstream offers in_data
//   in_ready   out  stage 0 accepts in_data this cycle
//   in_data    in   payload into stage 0
//   out_valid  out  stage DEPTH-1 presents out_data
//   out_ready  in   downstream accepts out_data
//   out_data   out  payload of stage DEPTH-1
//   stall      in   bit i: stage i holds, sends nothing, receives nothing
//   flush      in   bit i: kill stage i contents at next edge
//   occupancy  out  number of valid stages (register-only path)
//
// Optional feature (macro PIPE_PERF_CNT_EN)
//   perf_bubble_cnt  out  cycles with out_ready=1 and out_valid=0 (saturating)
//   perf_flush_cnt   out  valid entries killed by flush (saturating)

module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic [DEPTH-1:0]             stall,
  input  logic [DEPTH-1:0]             flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]             perf_bubble_cnt,
  output logic [CNT_W-1:0]             perf_flush_cnt
`endif
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  logic [DEPTH-1:0] w_blk;
  logic [DEPTH-1:0] w_move;
  logic [DEPTH-1:0] w_acc;
  logic [DEPTH-1:0] w_src_valid;
  logic [WIDTH-1:0] w_src_data [DEPTH];
  logic [OCC_W-1:0] w_occ;

  // A flushed stage behaves like a stalled one for the handshake: it neither
  // sends nor receives, so an upstream entry aimed at it waits instead of
  // being lost.
  assign w_blk = stall | flush;

  // Ready ripples from the output end toward stage 0. The running "open"
  // flag is kept in a block-local variable so the chain is a straight
  // combinational walk rather than a self-referencing vector.
  always_comb begin : p_handshake
    logic v_open;
    v_open = out_ready;
    w_move = '0;
    w_acc  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_move[i] = r_valid[i] & ~w_blk[i] & v_open;
      w_acc[i]  = ~w_blk[i] & (~r_valid[i] | w_move[i]);
      v_open    = w_acc[i];
    end
  end

  // What each stage would load when it accepts: stage 0 takes the input
  // port, every other stage takes its upstream neighbour if that one moves.
  for (genvar g = 0; g < DEPTH; g++) begin : g_src
    if (g == 0) begin : g_head
      assign w_src_valid[g] = in_valid;
      assign w_src_data[g]  = in_data;
    end else begin : g_body
      assign w_src_valid[g] = w_move[g-1];
      assign w_src_data[g]  = r_data[g-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush[i]) begin
          r_valid[i] <= 1'b0;
        end else if (w_acc[i]) begin
          r_valid[i] <= w_src_valid[i];
          // bubbles leave the payload untouched to avoid needless toggling
          if (w_src_valid[i]) begin
            r_data[i] <= w_src_data[i];
          end
        end
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OCC_W'(r_valid[i]);
    end
  end

  assign in_ready  = w_acc[0];
  assign out_valid = r_valid[DEPTH-1] & ~w_blk[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign occupancy = w_occ;

`ifdef PIPE_PERF_CNT_EN
  // Sums are computed one carry-space wider than the counter so saturation
  // is a plain compare against all-ones.
  localparam int SUM_W = CNT_W + OCC_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [OCC_W-1:0] w_kills;
  logic [SUM_W-1:0] w_bubble_sum;
  logic [SUM_W-1:0] w_flush_sum;

  always_comb begin
    w_kills = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kills = w_kills + OCC_W'(r_valid[i] & flush[i]);
    end
  end

  assign w_bubble_sum = SUM_W'(r_bubble_cnt) + SUM_W'(out_ready & ~out_valid);
  assign w_flush_sum  = SUM_W'(r_flush_cnt) + SUM_W'(w_kills);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_bubble_cnt <= (w_bubble_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_bubble_sum[CNT_W-1:0];
      r_flush_cnt  <= (w_flush_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_flush_sum[CNT_W-1:0];
    end
  end

  assign perf_bubble_cnt = r_bubble_cnt;
  assign perf_flush_cnt  = r_flush_cnt;
`endif

endmodule
